// File: rtl/dmio_pkg.sv
// Shared widths, default I/O addresses and the address-decode helper for the data-memory stage.
package dmio_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 64;
    localparam int IO_W   = 8;

    localparam logic [ADDR_W-1:0] DMIO_LED_ADDR = 13'h1FFE;
    localparam logic [ADDR_W-1:0] DMIO_SW_ADDR  = 13'h1FFF;

    typedef enum logic [1:0] {
        SEL_RAM = 2'd0,
        SEL_LED = 2'd1,
        SEL_SW  = 2'd2
    } dmioSel_e;

    // The two I/O addresses take priority; anything else falls through to RAM.
    function automatic dmioSel_e decodeSel(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] ledAddr,
        input logic [ADDR_W-1:0] swAddr
    );
        dmioSel_e sel;
        if (addr == ledAddr) begin
            sel = SEL_LED;
        end else if (addr == swAddr) begin
            sel = SEL_SW;
        end else begin
            sel = SEL_RAM;
        end
        return sel;
    endfunction

endpackage

// File: rtl/dmio_ram.sv
// Single-port word RAM: synchronous write, asynchronous read, contents never reset.
module dmio_ram
    import dmio_pkg::*;
#(
    parameter int RAM_AW = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [RAM_AW-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [2**RAM_AW];

    // Storage array write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/data_mem_io.sv
// Data-memory stage with memory-mapped LED latch and switch port.
// Optional macro SW_SYNC_EN adds a 2-flop synchronizer on the switch inputs.
module data_mem_io
    import dmio_pkg::*;
#(
    parameter int                RAM_AW   = 8,
    parameter logic [ADDR_W-1:0] LED_ADDR = DMIO_LED_ADDR,
    parameter logic [ADDR_W-1:0] SW_ADDR  = DMIO_SW_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] direccion,
    input  logic [DATA_W-1:0] dataWrite,
    input  logic [IO_W-1:0]   sw,
    input  logic              memWr,
    output logic [IO_W-1:0]   lecturaLED,
    output logic [DATA_W-1:0] dataRead
);

    dmioSel_e          sel_s;
    logic              ramWe_s;
    logic [DATA_W-1:0] ramRdata_s;
    logic [IO_W-1:0]   led_r;
    logic [IO_W-1:0]   swValue_s;

    assign sel_s = decodeSel(direccion, LED_ADDR, SW_ADDR);

    // RAM write enable; reset holds off every store
    always_comb begin
        ramWe_s = 1'b0;
        if (memWr && !reset && (sel_s == SEL_RAM)) begin
            ramWe_s = 1'b1;
        end else begin
            ramWe_s = 1'b0;
        end
    end

    dmio_ram #(
        .RAM_AW(RAM_AW)
    ) uRam (
        .clk  (clk),
        .we   (ramWe_s),
        .addr (direccion[RAM_AW-1:0]),
        .wdata(dataWrite),
        .rdata(ramRdata_s)
    );

    // LED output latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_r <= 8'h00;
        end else if (memWr && (sel_s == SEL_LED)) begin
            led_r <= dataWrite[IO_W-1:0];
        end else begin
            led_r <= led_r;
        end
    end

    assign lecturaLED = led_r;

`ifdef SW_SYNC_EN
    logic [IO_W-1:0] swMeta_r;
    logic [IO_W-1:0] swSync_r;

    // Two-stage synchronizer for the asynchronous switch inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            swMeta_r <= 8'h00;
            swSync_r <= 8'h00;
        end else begin
            swMeta_r <= sw;
            swSync_r <= swMeta_r;
        end
    end

    assign swValue_s = swSync_r;
`else
    assign swValue_s = sw;
`endif

    // Zero-latency load mux; no bypass of a store in flight
    always_comb begin
        dataRead = ramRdata_s;
        case (sel_s)
            SEL_LED: dataRead = {56'h0, led_r};
            SEL_SW:  dataRead = {56'h0, swValue_s};
            SEL_RAM: dataRead = ramRdata_s;
            default: dataRead = ramRdata_s;
        endcase
    end

endmodule

// File: tb/tb_data_mem_io.sv
// Directed self-checking bench for data_mem_io (honours SW_SYNC_EN when defined).
module tb_data_mem_io;

    localparam logic [12:0] LED_A = 13'h1FFE;
    localparam logic [12:0] SW_A  = 13'h1FFF;

    logic        clk;
    logic        reset;
    logic [12:0] direccion;
    logic [63:0] dataWrite;
    logic [7:0]  sw;
    logic        memWr;
    logic [7:0]  lecturaLED;
    logic [63:0] dataRead;

    int errors;
    int checks;

    data_mem_io dut (
        .clk       (clk),
        .reset     (reset),
        .direccion (direccion),
        .dataWrite (dataWrite),
        .sw        (sw),
        .memWr     (memWr),
        .lecturaLED(lecturaLED),
        .dataRead  (dataRead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single store: drive on the falling edge, commit on the rising edge.
    task automatic doWrite(input logic [12:0] a, input logic [63:0] d);
        @(negedge clk);
        direccion = a;
        dataWrite = d;
        memWr     = 1'b1;
        @(posedge clk);
        #1;
        memWr = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #12;
        checks++;
        if (lecturaLED !== 8'h00) begin
            errors++;
            $display("FAIL reset_led_held got=%h exp=%h", lecturaLED, 8'h00);
        end
        @(negedge clk);
        reset     = 1'b0;
        direccion = LED_A;
        #1;
        checks++;
        if (lecturaLED !== 8'h00) begin
            errors++;
            $display("FAIL reset_led got=%h exp=%h", lecturaLED, 8'h00);
        end
        checks++;
        if (dataRead !== 64'h0) begin
            errors++;
            $display("FAIL reset_read_led got=%h exp=%h", dataRead, 64'h0);
        end
    endtask

    task automatic test_ram_alias;
        doWrite(13'h1AF2, 64'hF);
        direccion = 13'h1AF2;
        #1;
        checks++;
        if (dataRead !== 64'hF) begin
            errors++;
            $display("FAIL ram_read got=%h exp=%h", dataRead, 64'hF);
        end
        direccion = 13'h00F2;
        #1;
        checks++;
        if (dataRead !== 64'hF) begin
            errors++;
            $display("FAIL ram_alias got=%h exp=%h", dataRead, 64'hF);
        end
    endtask

    task automatic test_sw;
        doWrite(13'h00FF, 64'h77);
        @(negedge clk);
        sw        = 8'hCA;
        direccion = SW_A;
`ifdef SW_SYNC_EN
        @(posedge clk);
        #1;
        checks++;
        if (dataRead !== 64'h0) begin
            errors++;
            $display("FAIL sw_lag1 got=%h exp=%h", dataRead, 64'h0);
        end
        @(posedge clk);
        #1;
`else
        #1;
`endif
        checks++;
        if (dataRead !== 64'hCA) begin
            errors++;
            $display("FAIL sw_read got=%h exp=%h", dataRead, 64'hCA);
        end
        doWrite(SW_A, 64'h55);
        direccion = SW_A;
        #1;
        checks++;
        if (dataRead !== 64'hCA) begin
            errors++;
            $display("FAIL sw_write_ignored got=%h exp=%h", dataRead, 64'hCA);
        end
        direccion = 13'h00FF;
        #1;
        checks++;
        if (dataRead !== 64'h77) begin
            errors++;
            $display("FAIL sw_write_no_ram got=%h exp=%h", dataRead, 64'h77);
        end
    endtask

    task automatic test_led;
        doWrite(13'h00FE, 64'h66);
        doWrite(13'h0020, 64'h1234);
        doWrite(LED_A, 64'hFFFF_FFFF_FFFF_FF5A);
        direccion = LED_A;
        #1;
        checks++;
        if (lecturaLED !== 8'h5A) begin
            errors++;
            $display("FAIL led_out got=%h exp=%h", lecturaLED, 8'h5A);
        end
        checks++;
        if (dataRead !== 64'h5A) begin
            errors++;
            $display("FAIL led_read got=%h exp=%h", dataRead, 64'h5A);
        end
        direccion = 13'h00FE;
        #1;
        checks++;
        if (dataRead !== 64'h66) begin
            errors++;
            $display("FAIL led_write_no_ram got=%h exp=%h", dataRead, 64'h66);
        end
        // Asynchronous reset away from any clock edge, with a store attempted while held
        @(negedge clk);
        #2;
        reset     = 1'b1;
        direccion = 13'h0020;
        dataWrite = 64'hDEAD;
        memWr     = 1'b1;
        #1;
        checks++;
        if (lecturaLED !== 8'h00) begin
            errors++;
            $display("FAIL led_async_reset got=%h exp=%h", lecturaLED, 8'h00);
        end
        @(posedge clk);
        @(negedge clk);
        memWr = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (dataRead !== 64'h1234) begin
            errors++;
            $display("FAIL reset_blocks_write got=%h exp=%h", dataRead, 64'h1234);
        end
    endtask

    task automatic test_no_write;
        doWrite(13'h3, 64'h33);
        doWrite(13'h4, 64'h44);
        doWrite(LED_A, 64'h3C);
        @(negedge clk);
        memWr     = 1'b0;
        dataWrite = 64'hA;
        direccion = 13'h3;
        @(posedge clk);
        @(negedge clk);
        direccion = 13'h4;
        @(posedge clk);
        #1;
        checks++;
        if (dataRead !== 64'h44) begin
            errors++;
            $display("FAIL nowr_word4 got=%h exp=%h", dataRead, 64'h44);
        end
        direccion = 13'h3;
        #1;
        checks++;
        if (dataRead !== 64'h33) begin
            errors++;
            $display("FAIL nowr_word3 got=%h exp=%h", dataRead, 64'h33);
        end
        checks++;
        if (lecturaLED !== 8'h3C) begin
            errors++;
            $display("FAIL nowr_led got=%h exp=%h", lecturaLED, 8'h3C);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        direccion = 13'h0010;
        dataWrite = 64'h1;
        memWr     = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (dataRead !== 64'h1) begin
            errors++;
            $display("FAIL b2b_edge1 got=%h exp=%h", dataRead, 64'h1);
        end
        @(negedge clk);
        dataWrite = 64'h2;
        #1;
        checks++;
        if (dataRead !== 64'h1) begin
            errors++;
            $display("FAIL b2b_no_bypass got=%h exp=%h", dataRead, 64'h1);
        end
        @(posedge clk);
        #1;
        memWr = 1'b0;
        checks++;
        if (dataRead !== 64'h2) begin
            errors++;
            $display("FAIL b2b_edge2 got=%h exp=%h", dataRead, 64'h2);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        direccion = 13'h0;
        dataWrite = 64'h0;
        sw        = 8'h00;
        memWr     = 1'b0;
        test_reset();
        test_ram_alias();
        test_sw();
        test_led();
        test_no_write();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
